// File: rtl/dcpu16_pkg.sv
// dcpu16_pkg: shared definitions for the DCPU-16 memory arbiter.
//   WORD_W   - data/address word width
//   TMO_FILL - read data returned when a bus access times out
//   state_t  - arbiter state encoding
package dcpu16_pkg;

    localparam int unsigned WORD_W = 16;

    localparam logic [WORD_W-1:0] TMO_FILL = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_F = 2'd1,
        RUN_G = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dcpu16_arb.sv
// dcpu16_arb: serialises the F-bus (fetch/write) and G-bus (operand read)
// requests of the memory-bus stage onto one simplified-Wishbone master port.
// F is served before G, and both acks are returned together in a single
// cycle so the upstream stall term releases once per transaction pair.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   f_adr/f_stb/f_wre/f_dto       F-bus request (read or write)
//   f_dti/f_ack                   F-bus read data / acknowledge
//   g_adr/g_stb                   G-bus request (read only)
//   g_dti/g_ack                   G-bus read data / acknowledge
//   m_adr/m_stb/m_wre/m_dto       memory master request
//   m_dti/m_ack                   memory read data / acknowledge
//   err                           sticky bus-timeout flag
//
// Build option:
//   DCPU16_ARB_TIMEOUT_EN - when defined, an access that waits 2^TMO_W-1
//   cycles without m_ack completes with read data 16'hFFFF and sets err.
//   When undefined the arbiter waits indefinitely and err is tied low.
module dcpu16_arb
    import dcpu16_pkg::*;
#(
    parameter int unsigned TMO_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] f_adr,
    input  logic              f_stb,
    input  logic              f_wre,
    input  logic [WORD_W-1:0] f_dto,
    output logic [WORD_W-1:0] f_dti,
    output logic              f_ack,
    input  logic [WORD_W-1:0] g_adr,
    input  logic              g_stb,
    output logic [WORD_W-1:0] g_dti,
    output logic              g_ack,
    output logic [WORD_W-1:0] m_adr,
    output logic              m_stb,
    output logic              m_wre,
    output logic [WORD_W-1:0] m_dto,
    input  logic [WORD_W-1:0] m_dti,
    input  logic              m_ack,
    output logic              err
);

    generate
        if (TMO_W < 1) begin : g_bad_tmo_w
            $error("dcpu16_arb: TMO_W must be at least 1");
        end
    endgenerate

    state_t            state;
    logic              pf;
    logic              pg;
    logic              xfer_done;
    logic [WORD_W-1:0] rd_data;

`ifdef DCPU16_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             running;
    logic             tmo;

    assign running   = (state == RUN_F) || (state == RUN_G);
    // A real ack always wins over a timeout landing in the same cycle.
    assign tmo       = running && !m_ack && (tmo_cnt == '1);
    assign xfer_done = m_ack || tmo;
    assign rd_data   = m_ack ? m_dti : TMO_FILL;

    // Every completion is a state change, so the counter only needs to
    // run while an access is outstanding and clear otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (running && !xfer_done) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (tmo) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign xfer_done = m_ack;
    assign rd_data   = m_dti;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pf    <= 1'b0;
            pg    <= 1'b0;
            f_dti <= '0;
            f_ack <= 1'b0;
            g_dti <= '0;
            g_ack <= 1'b0;
            m_adr <= '0;
            m_stb <= 1'b0;
            m_wre <= 1'b0;
            m_dto <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pf <= f_stb;
                    pg <= g_stb;
                    if (f_stb) begin
                        state <= RUN_F;
                        m_adr <= f_adr;
                        m_wre <= f_wre;
                        m_dto <= f_dto;
                        m_stb <= 1'b1;
                    end else if (g_stb) begin
                        state <= RUN_G;
                        m_adr <= g_adr;
                        m_wre <= 1'b0;
                        m_stb <= 1'b1;
                    end
                end

                RUN_F: begin
                    if (xfer_done) begin
                        // m_wre holds the F-bus write enable for this access.
                        if (!m_wre) begin
                            f_dti <= rd_data;
                        end
                        m_wre <= 1'b0;
                        if (pg) begin
                            state <= RUN_G;
                            m_adr <= g_adr;
                        end else begin
                            state <= DONE;
                            m_stb <= 1'b0;
                            f_ack <= pf;
                            g_ack <= pg;
                        end
                    end
                end

                RUN_G: begin
                    if (xfer_done) begin
                        g_dti <= rd_data;
                        state <= DONE;
                        m_stb <= 1'b0;
                        f_ack <= pf;
                        g_ack <= pg;
                    end
                end

                DONE: begin
                    // Acks are visible for exactly this cycle; strobes are
                    // not sampled here so the stale requests are not re-served.
                    f_ack <= 1'b0;
                    g_ack <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcpu16_arb.sv
// tb_dcpu16_arb: randomized self-checking bench for dcpu16_arb.
// A behavioural memory with programmable wait states answers the master
// port; a shadow memory plus per-bus read-data registers predict what each
// transaction pair returns, in which order memory is touched, and when the
// joint ack appears.
module tb_dcpu16_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] f_adr, f_dto, f_dti;
    logic        f_stb, f_wre, f_ack;
    logic [15:0] g_adr, g_dti;
    logic        g_stb, g_ack;
    logic [15:0] m_adr, m_dto, m_dti;
    logic        m_stb, m_wre, m_ack;
    logic        err;

    localparam int unsigned TMO_W = 4;

    dcpu16_arb #(.TMO_W(TMO_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .f_adr (f_adr),
        .f_stb (f_stb),
        .f_wre (f_wre),
        .f_dto (f_dto),
        .f_dti (f_dti),
        .f_ack (f_ack),
        .g_adr (g_adr),
        .g_stb (g_stb),
        .g_dti (g_dti),
        .g_ack (g_ack),
        .m_adr (m_adr),
        .m_stb (m_stb),
        .m_wre (m_wre),
        .m_dto (m_dto),
        .m_dti (m_dti),
        .m_ack (m_ack),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Memory model
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    int          wait_n = 0;
    int          wcnt   = 0;
    bit          mute   = 1'b0;
    logic [16:0] acc_log [$];
    bit          held   = 1'b0;
    logic [15:0] held_adr;
    int          stab_bad = 0;

    assign m_ack = m_stb && !mute && (wcnt >= wait_n);
    assign m_dti = mem[m_adr];

    always @(posedge clk) begin
        if (rst || !m_stb || m_ack) wcnt <= 0;
        else                        wcnt <= wcnt + 1;
        if (!rst && m_stb && m_ack) begin
            if (m_wre) mem[m_adr] <= m_dto;
            acc_log.push_back({m_wre, m_adr});
        end
        if (held && m_stb && (m_adr != held_adr)) stab_bad++;
        held     <= !rst && m_stb && !m_ack;
        held_adr <= m_adr;
    end

    // Checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference read-data registers
    logic [15:0] mf = 16'h0;
    logic [15:0] mg = 16'h0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one transaction pair from an IDLE-cycle negedge and check it.
    task automatic do_pair(input bit rf, input bit rg, input bit fw,
                           input logic [15:0] fa, input logic [15:0] fd,
                           input logic [15:0] ga, input int w, input bit hold);
        int n, lat, edges, idx;
        n   = int'(rf) + int'(rg);
        lat = 1 + n * (w + 1);
        if (rf) begin
            if (fw) ref_mem[fa] = fd;
            else    mf = ref_mem[fa];
        end
        if (rg) mg = ref_mem[ga];
        acc_log.delete();
        wait_n = w;
        f_stb = rf; f_wre = fw; f_adr = fa; f_dto = fd;
        g_stb = rg; g_adr = ga;
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!(f_ack || g_ack) && edges < 300);
        check("latency", 32'(edges), 32'(lat));
        check("f_ack", 32'(f_ack), 32'(rf));
        check("g_ack", 32'(g_ack), 32'(rg));
        check("f_dti", 32'(f_dti), 32'(mf));
        check("g_dti", 32'(g_dti), 32'(mg));
        check("accesses", 32'(acc_log.size()), 32'(n));
        if (acc_log.size() == n) begin
            idx = 0;
            if (rf) begin
                check("f_access", 32'(acc_log[0]), 32'({fw, fa}));
                idx = 1;
            end
            if (rg) check("g_access", 32'(acc_log[idx]), 32'({1'b0, ga}));
        end
        if (!hold) begin
            f_stb = 1'b0;
            g_stb = 1'b0;
        end
        tick();
        check("ack_pulse", 32'({f_ack, g_ack}), 32'(0));
        check("m_stb_idle", 32'(m_stb), 32'(0));
    endtask

    initial begin
        logic [15:0] v;
        bit rf, rg, fw, hold;
        logic [15:0] fa, ga;
        int edges;

        for (int i = 0; i < 65536; i++) begin
            v = 16'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[16'h0010] = 16'h7C01;
        ref_mem[16'h0010] = 16'h7C01;

        rst = 1'b1;
        f_stb = 1'b0; f_wre = 1'b0; f_adr = '0; f_dto = '0;
        g_stb = 1'b0; g_adr = '0;
        repeat (3) tick();
        check("rst_outs", 32'({f_dti, g_dti}), 32'(0));
        check("rst_m", 32'({m_adr, m_dto}), 32'(0));
        check("rst_ctl", 32'({f_ack, g_ack, m_stb, m_wre, err}), 32'(0));
        rst = 1'b0;
        tick();

        // Directed cases
        do_pair(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h0, 0, 1'b0);
        check("read_7c01", 32'(f_dti), 32'h7C01);
        do_pair(1'b1, 1'b1, 1'b1, 16'h1000, 16'hBEEF, 16'h1000, 0, 1'b0);
        check("wr_rd_beef", 32'(g_dti), 32'hBEEF);
        do_pair(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h0021, 5, 1'b0);
        do_pair(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0002, 0, 1'b1);
        do_pair(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0003, 0, 1'b0);

        // Reset during RUN_G
        g_stb = 1'b1; g_adr = 16'h0030; wait_n = 10;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_stb", 32'(m_stb), 32'(0));
        check("rst_mid_ack", 32'({f_ack, g_ack}), 32'(0));
        mf = 16'h0; mg = 16'h0;
        g_stb = 1'b0;
        rst = 1'b0;
        tick();
        do_pair(1'b1, 1'b1, 1'b0, 16'h0031, 16'h0, 16'h0032, 1, 1'b0);

        // Randomized pairs
        for (int t = 0; t < 40; t++) begin
            rf = 1'($urandom);
            rg = 1'($urandom);
            if (!rf && !rg) rg = 1'b1;
            fw = 1'($urandom);
            fa = {12'h100, 4'($urandom)};
            ga = ($urandom_range(0, 1) == 0) ? fa : {12'h100, 4'($urandom)};
            hold = (t != 39) && ($urandom_range(0, 3) == 0);
            do_pair(rf, rg, fw, fa, 16'($urandom), ga, $urandom_range(0, 3), hold);
            if (!hold) repeat ($urandom_range(0, 2)) tick();
        end
        check("adr_stable", 32'(stab_bad), 32'(0));

`ifdef DCPU16_ARB_TIMEOUT_EN
        mute = 1'b1;
        g_stb = 1'b1; g_adr = 16'h0040;
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!(f_ack || g_ack) && edges < 300);
        check("tmo_latency", 32'(edges), 32'(1 + (1 << TMO_W)));
        check("tmo_ack", 32'({f_ack, g_ack}), 32'b01);
        check("tmo_data", 32'(g_dti), 32'hFFFF);
        check("tmo_err", 32'(err), 32'(1));
        mg = 16'hFFFF;
        mute = 1'b0;
        g_stb = 1'b0;
        tick();
        do_pair(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0041, 0, 1'b0);
        check("err_sticky", 32'(err), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_cleared", 32'(err), 32'(0));
`else
        check("err_off", 32'(err), 32'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
